// File: rtl/key_expansion_ctrl.sv
`timescale 1ns/1ps
// key_expansion_ctrl
//
// Purpose: AES key-schedule sequencer for AES-128/192/256. It streams the
// round-key words w[0..Ntot-1] over a valid/ready port, one word per two
// cycles. Only the last Nk words are kept in an 8x32 sliding window. SubWord
// is evaluated by a shared external combinational S-box unit.
//
// Build option: define KEYEXP_READBACK_EN to add a 60x32 store of every
// accepted word, read through rd_addr/rd_data with one cycle of latency.
// Without it, rd_data is tied to 0 and rd_addr is ignored.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   start            begin expansion (sampled only in IDLE)
//   key_len          00=AES-128, 01=AES-192, 10=AES-256, 11 treated as 00
//   key_in           cipher key, w[0] = key_in[255:224]
//   sbox_in/out      word sent to / SubWord result from the external S-box
//   word_valid/ready output handshake
//   word_out         round-key word w[word_idx]
//   word_idx         index of word_out
//   busy             high in every state except IDLE
//   done             one-cycle pulse after the last word is accepted
//   rd_addr/rd_data  readback port (active only with KEYEXP_READBACK_EN)
//   state_dbg        current FSM state, for debug and checkers
//
// Handshake: a word is transferred on a rising edge where word_valid and
// word_ready are both high. While word_valid=1, word_out and word_idx stay
// stable until that transfer. word_valid never drops without a transfer,
// except on reset.
module key_expansion_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic [5:0]   word_idx,
  output logic         busy,
  output logic         done,
  input  logic [5:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  klen;       // latched key length, 11 already folded to 00
  logic [31:0] win [8];    // win[0] = w[i-Nk] ... win[Nk-1] = w[i-1]
  logic [5:0]  cnt_i;      // index of the next word to produce
  logic [2:0]  kmod;       // cnt_i mod Nk, kept by wrapping
  logic [7:0]  rcon;

  logic [2:0]  nk_m1;
  logic [5:0]  last_idx;
  logic        accept, compute, need_rot, need_sub;
  logic [31:0] prev_w, temp, next_word;

  // ---------------- configuration decode ----------------
  always_comb begin
    nk_m1    = 3'd3;
    last_idx = 6'd43;
    case (klen)
      2'b01: begin nk_m1 = 3'd5; last_idx = 6'd51; end
      2'b10: begin nk_m1 = 3'd7; last_idx = 6'd59; end
      default: ;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state and status outputs ----------------
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    state_dbg = state;
    case (state)
      IDLE:   if (start) state_nx = LOAD;
      LOAD:   if (accept && (kmod == nk_m1)) state_nx = EXPAND;
      EXPAND: if (accept && (cnt_i == last_idx)) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- word datapath ----------------
  always_comb begin
    accept   = word_valid && word_ready;
    // Even cycles compute and register a word; odd cycles wait for acceptance.
    compute  = ((state == LOAD) || (state == EXPAND)) && !word_valid;
    prev_w   = win[nk_m1];
    need_rot = (state == EXPAND) && (kmod == 3'd0);
    need_sub = (state == EXPAND) && (klen == 2'b10) && (kmod == 3'd4);
    sbox_in  = 32'h0;
    if (compute && need_rot)      sbox_in = {prev_w[23:0], prev_w[31:24]};
    else if (compute && need_sub) sbox_in = prev_w;
    temp = prev_w;
    if (need_rot)      temp = sbox_out ^ {rcon, 24'h0};
    else if (need_sub) temp = sbox_out;
    // In LOAD the window still holds the raw key, and kmod equals the index.
    next_word = (state == LOAD) ? win[kmod] : (win[0] ^ temp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klen       <= 2'b00;
      cnt_i      <= 6'd0;
      kmod       <= 3'd0;
      rcon       <= 8'h01;
      word_valid <= 1'b0;
      word_out   <= 32'h0;
      word_idx   <= 6'd0;
      for (int j = 0; j < 8; j++) win[j] <= 32'h0;
    end else if ((state == IDLE) && start) begin
      klen       <= (key_len == 2'b11) ? 2'b00 : key_len;
      cnt_i      <= 6'd0;
      kmod       <= 3'd0;
      rcon       <= 8'h01;
      word_valid <= 1'b0;
      for (int j = 0; j < 8; j++) win[j] <= key_in[255 - 32*j -: 32];
    end else if (compute) begin
      word_out   <= next_word;
      word_idx   <= cnt_i;
      word_valid <= 1'b1;
      // xtime: multiply by x in GF(2^8)
      if (need_rot) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end else if (accept) begin
      word_valid <= 1'b0;
      cnt_i      <= cnt_i + 6'd1;
      kmod       <= (kmod == nk_m1) ? 3'd0 : kmod + 3'd1;
      // Slide the window only once words are derived; LOAD reads the key in place.
      if (state == EXPAND) begin
        for (int j = 0; j < 7; j++) begin
          if (3'(j) < nk_m1)       win[j] <= win[j + 1];
          else if (3'(j) == nk_m1) win[j] <= word_out;
        end
        if (nk_m1 == 3'd7) win[7] <= word_out;
      end
    end
  end

  // ---------------- optional readback store ----------------
`ifdef KEYEXP_READBACK_EN
  logic [31:0] mem [60];

  // No reset: the stored schedule survives a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (accept) mem[word_idx] <= word_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_data <= 32'h0;
    else if (rd_addr < 6'd60)  rd_data <= mem[rd_addr];
    else                       rd_data <= 32'h0;
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 32'h0;
`endif

endmodule

// File: tb/tb_key_expansion_ctrl.sv
`timescale 1ns/1ps
// tb_key_expansion_ctrl: randomized key-schedule bench with a reference model
// and a scoreboard of expected {idx, word} pairs.
module tb_key_expansion_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key_in = '0;
  logic [31:0]  sbox_in, sbox_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [31:0]  word_out;
  logic [5:0]   word_idx;
  logic         busy, done;
  logic [5:0]   rd_addr = 6'd0;
  logic [31:0]  rd_data;
  logic [1:0]   state_dbg;

  key_expansion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .word_valid(word_valid),
    .word_ready(word_ready), .word_out(word_out), .word_idx(word_idx),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- AES S-box (external SubWord unit) ----------------
  localparam logic [127:0] SBOX [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    int c;
    row = SBOX[b[7:4]];
    c   = int'(b[3:0]);
    return row[127 - 8*c -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  assign sbox_out = sub_word(sbox_in);

  // ---------------- bookkeeping ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [37:0] exp_q[$];          // {word_idx, word}
  logic [31:0] ref_w [60];
  logic [31:0] dut_w [64];
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Textbook key schedule over a flat array, then queue every word in order.
  task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
    logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int nk, ntot;
    logic [31:0] t;
    nk   = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    ntot = 4 * (nk + 7);
    for (int i = 0; i < ntot; i++) begin
      if (i < nk) ref_w[i] = key[255 - 32*i -: 32];
      else begin
        t = ref_w[i-1];
        if (i % nk == 0)
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4)
          t = sub_word(t);
        ref_w[i] = ref_w[i-nk] ^ t;
      end
      exp_q.push_back({6'(i), ref_w[i]});
    end
  endtask

  // ---------------- monitor ----------------
  logic        mon_stall = 1'b0;
  logic [37:0] mon_hold = '0;
  logic [37:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) mon_stall = 1'b0;
    else begin
      if (done) done_cnt++;
      if (mon_stall)
        check("stall_hold", {25'b0, word_valid, word_idx, word_out}, {25'b0, 1'b1, mon_hold});
      if (word_valid && word_ready) begin
        dut_w[word_idx] = word_out;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got idx %0d word %h, expected none", word_idx, word_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", {26'b0, word_idx, word_out}, {26'b0, mon_e});
        end
      end
      mon_stall = word_valid && !word_ready;
      mon_hold  = {word_idx, word_out};
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic run_exp(input logic [1:0] kl, input logic [255:0] key,
                         input int ready_pct, input bit junk);
    int cyc;
    bit fin;
    for (int i = 0; i < 64; i++) dut_w[i] = '0;
    model_expand(kl, key);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; key_len = kl; key_in = key;
    word_ready = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk); #1;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    start = 1'b0;
    if (junk) begin
      key_in  = rand_key();
      key_len = 2'($urandom_range(0, 3));
    end
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 4000) begin
      word_ready = ($urandom_range(0, 99) < ready_pct);
      if (junk) start = ($urandom_range(0, 3) == 0);
      if (done) begin
        start = junk;          // a start in the DONE cycle must be ignored
        fin   = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
      do_reset();
    end else begin
      check("idle_after_done", {62'b0, busy, done}, 64'd0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("done_pulses", 64'(done_cnt), 64'd1);
    end
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  localparam logic [255:0] KEY128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  initial begin
    int cyc;
    bit hit;
    // reset state
    #12;
    check("reset_outputs", {word_valid, word_idx, word_out, busy, done}, 64'd0);
    check("reset_sbox_in", {32'b0, sbox_in}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // AES-128 known answer, always ready
    run_exp(2'b00, KEY128, 100, 1'b0);
    check("aes128_w0", {32'b0, dut_w[0]}, 64'h2b7e1516);
    check("aes128_w4", {32'b0, dut_w[4]}, 64'ha0fafe17);
    check("aes128_w43", {32'b0, dut_w[43]}, 64'hb6630ca6);

    // AES-192 known answer
    run_exp(2'b01, KEY192, 100, 1'b0);
    check("aes192_w6", {32'b0, dut_w[6]}, 64'hfe0c91f7);
    check("aes192_w51", {32'b0, dut_w[51]}, 64'h01002202);

    // AES-256 known answer
    run_exp(2'b10, KEY256, 100, 1'b0);
    check("aes256_w8", {32'b0, dut_w[8]}, 64'h9ba35411);
    check("aes256_w59", {32'b0, dut_w[59]}, 64'h706c631e);

`ifdef KEYEXP_READBACK_EN
    rd_addr = 6'd59;
    @(posedge clk); #1;
    check("rb_addr59", {32'b0, rd_data}, 64'h706c631e);
    rd_addr = 6'd60;
    @(posedge clk); #1;
    check("rb_addr60", {32'b0, rd_data}, 64'h0);
    rd_addr = 6'd8;
    @(posedge clk); #1;
    check("rb_addr8", {32'b0, rd_data}, 64'h9ba35411);
`else
    for (int i = 0; i < 3; i++) begin
      rd_addr = 6'($urandom_range(0, 63));
      @(posedge clk); #1;
      check("rd_data_zero", {32'b0, rd_data}, 64'h0);
    end
`endif

    // AES-128 with 50% backpressure, stray starts and key changes while busy
    run_exp(2'b00, KEY128, 50, 1'b1);
    check("aes128_stall_w43", {32'b0, dut_w[43]}, 64'hb6630ca6);

    // reset in the middle of an expansion
    model_expand(2'b00, KEY128);
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'b00; key_in = KEY128; word_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 500) begin
      if (word_valid && word_idx == 6'd20) hit = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("reached_idx20", {63'b0, hit}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {word_valid, word_idx, word_out, busy, done}, 64'd0);
    check("midrun_reset_sbox_in", {32'b0, sbox_in}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    run_exp(2'b00, KEY128, 100, 1'b0);
    check("restart_w0", {32'b0, dut_w[0]}, 64'h2b7e1516);
    check("restart_w4", {32'b0, dut_w[4]}, 64'ha0fafe17);
    check("restart_w43", {32'b0, dut_w[43]}, 64'hb6630ca6);

    // random keys, lengths (including 11), backpressure and stray inputs
    for (int r = 0; r < 8; r++)
      run_exp(2'($urandom_range(0, 3)), rand_key(), $urandom_range(30, 100),
              1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: begin expansion; sampled only in IDLE.
REQ-004 SHALL have port key_len, input, 2 bits: 00=AES-128 (Nk=4), 01=AES-192 (Nk=6), 10=AES-256 (Nk=8); 11 treated as 00.
REQ-005 SHALL have port key_in, input, 256 bits: cipher key; w[0]=key_in[255:224], w[1]=key_in[223:192], and so on; unused low words ignored.
REQ-006 SHALL have port sbox_in, output, 32 bits: word presented to the shared external combinational SubWord unit.
REQ-007 SHALL have port sbox_out, input, 32 bits: SubWord(sbox_in), valid in the same cycle.
REQ-008 SHALL have port word_valid, output, 1 bit: word_out/word_idx valid.
REQ-009 SHALL have port word_ready, input, 1 bit: consumer accepts the word when word_valid and word_ready are both high.
REQ-010 SHALL have port word_out, output, 32 bits: round-key word w[word_idx].
REQ-011 SHALL have port word_idx, output, 6 bits: index i of word_out.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-014 SHALL have port rd_addr, input, 6 bits: readback address (see Configuration).
REQ-015 SHALL have port rd_data, output, 32 bits: readback data (see Configuration).

Function
REQ-016 SHALL implement a state machine with states IDLE, LOAD, EXPAND and DONE.
REQ-017 IDLE->LOAD SHALL occur when start=1; key_len and key_in are latched at the same edge, and later changes to either are ignored until the next start.
REQ-018 LOAD SHALL emit w[0..Nk-1] unchanged, one word per accepted handshake, then move to EXPAND.
REQ-019 EXPAND SHALL emit w[Nk..Ntot-1], where Ntot=44/52/60 for Nk=4/6/8, then move to DONE.
REQ-020 For i>=Nk, the block SHALL compute w[i]=w[i-Nk] XOR temp, with temp=w[i-1], subject to REQ-021 and REQ-022.
REQ-021 When i mod Nk=0, temp SHALL be SubWord(RotWord(w[i-1])) XOR {rcon,24'h0}.
REQ-022 When Nk=8 and i mod Nk=4, temp SHALL be SubWord(w[i-1]).
REQ-023 The block SHALL hold the last Nk words in an internal 8x32 window; it SHALL NOT recompute any earlier word.
REQ-024 The block SHALL track i mod Nk with a wrapping counter; no divider is permitted.
REQ-025 rcon SHALL be an 8-bit register loaded with 0x01 on start and updated with xtime after each use (0x80->0x1B, 0x1B->0x36).
REQ-026 sbox_in SHALL be driven combinationally from the window; it SHALL be 0 when no SubWord is needed.
REQ-027 A word SHALL be registered and presented with word_valid=1 one cycle after the previous word is accepted, giving a throughput of 1 word per 2 cycles.
REQ-028 While word_valid=1 and word_ready=0, word_out, word_idx and all internal state SHALL hold.
REQ-029 DONE SHALL assert done for exactly one cycle and then return to IDLE; start in the DONE cycle SHALL be ignored.
REQ-030 start while busy=1 SHALL be ignored.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-expansion, SHALL asynchronously force IDLE and clear the window and counters.
REQ-032 On reset, the block SHALL drive word_valid=0, word_out=0, word_idx=0, busy=0, done=0 and rcon=0x01.
REQ-033 Reset SHALL NOT clear readback storage contents.

Configuration
REQ-034 With KEYEXP_READBACK_EN defined, each accepted word SHALL be written to a 60x32 storage at address word_idx, and rd_data SHALL be that storage at rd_addr, registered with 1-cycle latency.
REQ-035 With KEYEXP_READBACK_EN defined, rd_addr>=60 SHALL return 0.
REQ-036 Without KEYEXP_READBACK_EN, the storage SHALL be absent, rd_data SHALL be constant 0 and rd_addr SHALL be ignored.

Verification
REQ-037 key_len=00, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, word_ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6, 44 words, then one done pulse.
REQ-038 key_len=01, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
REQ-039 key_len=10, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411, w[59]=706c631e.
REQ-040 AES-128 run with word_ready randomly low 50% of cycles -> identical word stream; word_out stable while stalled.
REQ-041 rst_n pulsed low at word_idx=20, then restart -> outputs zero immediately, and the restart reproduces REQ-037 from w[0].
REQ-042 With KEYEXP_READBACK_EN defined, after REQ-039 run, rd_addr=59 -> rd_data=706c631e next cycle; rd_addr=60 -> rd_data=0.
